// File: rtl/pixel_eval_arbiter.sv
// pixel_eval_arbiter: round-robin share of one registered pixel_eval input slot among NUM_REQ units.
// Define PIXEL_ARB_BURST_LOCK_EN to hold a grant until req_last so a triangle's beats stay contiguous.
package pixel_arb_pkg;
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [31:0] rgba;
    } pixel_state_t;
endpackage

module pixel_eval_arbiter
    import pixel_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  pixel_state_t       req_pixel [NUM_REQ],
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_last,
    output logic [NUM_REQ-1:0] req_ready,
    output pixel_state_t       out_pixel,
    output logic [ID_W-1:0]    out_src,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);
    logic [ID_W-1:0] rr_ptr, rr_sel, idx, grant, sel, rr_nxt;
    logic rr_hit, locked, sel_valid, slot_free, accept, ends_grant;
    always_comb begin
        rr_sel = '0;
        rr_hit = 1'b0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                rr_sel = idx;
                rr_hit = 1'b1;
            end
        end
    end
    assign sel       = locked ? grant : rr_sel;
    assign sel_valid = locked ? req_valid[grant] : rr_hit;
    assign slot_free = !out_valid || out_ready;
    assign accept    = slot_free && sel_valid;
    assign req_ready = (rst || !accept) ? '0 : NUM_REQ'(1) << sel;
    assign rr_nxt    = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    assign busy      = out_valid || locked || (|req_valid);
`ifdef PIXEL_ARB_BURST_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_nxt;
    logic [ID_W-1:0] grant_nxt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        if (accept) begin
            state_nxt = req_last[sel] ? IDLE : LOCKED;
            grant_nxt = sel;
        end
    end
    assign locked     = state == LOCKED;
    assign ends_grant = req_last[sel];
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign locked      = 1'b0;
    assign grant       = '0;
    assign ends_grant  = 1'b1;
`endif
    // A new accept overwrites the slot even when the old beat leaves this same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_pixel <= req_pixel[sel];
            out_src   <= sel;
            if (ends_grant)
                rr_ptr <= rr_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
